// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the single-port RAM arbiter: FSM states, grant codes
// and the default word-address width.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_I = 2'd0,
        GNT_D = 2'd1,
        GNT_L = 2'd2
    } gnt_t;

    // A tie between I and D goes to the side that was not served last.
    function automatic gnt_t rr_tie_winner(input gnt_t last_grant);
        gnt_t w_pick;
        if (last_grant == GNT_I) begin
            w_pick = GNT_D;
        end else begin
            w_pick = GNT_I;
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick between instruction fetch and data requests,
// with a per-side mask for the requester currently being acknowledged.
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic [1:0] i_mask,
    input  gnt_t       i_last_grant,
    output logic       o_valid,
    output gnt_t       o_grant
);

    logic w_req_i;
    logic w_req_d;

    // i_mask[0] hides I, i_mask[1] hides D.
    assign w_req_i = i_req_i & ~i_mask[0];
    assign w_req_d = i_req_d & ~i_mask[1];

    // Grant selection from the unmasked requests.
    always_comb begin
        o_valid = 1'b0;
        o_grant = GNT_I;
        case ({w_req_i, w_req_d})
            2'b11: begin
                o_valid = 1'b1;
                o_grant = rr_tie_winner(i_last_grant);
            end
            2'b10: begin
                o_valid = 1'b1;
                o_grant = GNT_I;
            end
            2'b01: begin
                o_valid = 1'b1;
                o_grant = GNT_D;
            end
            default: begin
                o_valid = 1'b0;
                o_grant = GNT_I;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between I-fetch, data and
// (when MEM_ARBITER_LOADER_EN is defined) a full-word loader write port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
`ifdef MEM_ARBITER_LOADER_EN
    input  logic              l_req,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_ack,
`endif
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t      r_state;
    gnt_t        r_grant;
    gnt_t        r_last_grant;
    logic        r_mem_en;
    logic        r_i_ack;
    logic        r_d_ack;
    logic        r_l_ack;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_l_req;
    logic [31:0] w_l_addr;
    logic [31:0] w_l_wdata;
    logic        w_in_resp;
    logic [1:0]  w_mask;
    logic        w_l_cand;
    logic        w_rr_valid;
    gnt_t        w_rr_grant;
    logic        w_win_valid;
    gnt_t        w_win_grant;
    logic [31:0] w_sel_addr;
    logic [3:0]  w_we;
    logic        w_unused_bits;

`ifdef MEM_ARBITER_LOADER_EN
    assign w_l_req   = l_req;
    assign w_l_addr  = l_addr;
    assign w_l_wdata = l_wdata;
    assign l_ack     = r_l_ack;
`else
    logic w_unused_l;
    assign w_l_req    = 1'b0;
    assign w_l_addr   = 32'h0000_0000;
    assign w_l_wdata  = 32'h0000_0000;
    assign w_unused_l = r_l_ack;
`endif

    // The side being acknowledged still holds its req; hide it from the chaining decision.
    assign w_in_resp = (r_state == ST_RESP);
    assign w_mask    = {w_in_resp && (r_grant == GNT_D), w_in_resp && (r_grant == GNT_I)};
    assign w_l_cand  = w_l_req && !(w_in_resp && (r_grant == GNT_L));

    mem_arb_rr u_rr (
        .i_req_i      (i_req),
        .i_req_d      (d_req),
        .i_mask       (w_mask),
        .i_last_grant (r_last_grant),
        .o_valid      (w_rr_valid),
        .o_grant      (w_rr_grant)
    );

    assign w_win_valid = w_l_cand | w_rr_valid;
    assign w_win_grant = w_l_cand ? GNT_L : w_rr_grant;

    // Arbiter FSM: grant latch, round-robin history, RAM enable, acks and read-data hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_I;
            r_last_grant <= GNT_D;
            r_mem_en     <= 1'b0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_l_ack      <= 1'b0;
            r_i_rdata    <= 32'h0000_0000;
            r_d_rdata    <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_l_ack <= 1'b0;
                    if (w_in_resp && (r_grant == GNT_I)) begin
                        r_i_rdata <= mem_rdata;
                    end else if (w_in_resp && (r_grant == GNT_D)) begin
                        r_d_rdata <= mem_rdata;
                    end else begin
                        r_i_rdata <= r_i_rdata;
                    end
                    if (w_win_valid) begin
                        r_state  <= ST_ACCESS;
                        r_grant  <= w_win_grant;
                        r_mem_en <= 1'b1;
                        if (w_win_grant != GNT_L) begin
                            r_last_grant <= w_win_grant;
                        end else begin
                            r_last_grant <= r_last_grant;
                        end
                    end else begin
                        r_state  <= ST_IDLE;
                        r_mem_en <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    r_state  <= ST_RESP;
                    r_mem_en <= 1'b0;
                    r_i_ack  <= (r_grant == GNT_I);
                    r_d_ack  <= (r_grant == GNT_D);
                    r_l_ack  <= (r_grant == GNT_L);
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_i_ack  <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_l_ack  <= 1'b0;
                end
            endcase
        end
    end

    // RAM port steering from the latched grant; requesters hold addr/wdata until ack.
    always_comb begin
        w_sel_addr = i_addr;
        mem_wdata  = 32'h0000_0000;
        w_we       = 4'h0;
        case (r_grant)
            GNT_I: begin
                w_sel_addr = i_addr;
            end
            GNT_D: begin
                w_sel_addr = d_addr;
                mem_wdata  = d_wdata;
                w_we       = d_we ? d_wstrb : 4'h0;
            end
            GNT_L: begin
                w_sel_addr = w_l_addr;
                mem_wdata  = w_l_wdata;
                w_we       = 4'hF;
            end
            default: begin
                w_sel_addr = i_addr;
                w_we       = 4'h0;
            end
        endcase
    end

    assign mem_en   = r_mem_en;
    assign mem_we   = r_mem_en ? w_we : 4'h0;
    assign mem_addr = w_sel_addr[ADDR_W+1:2];

    // Byte offset and bits above the RAM size wrap silently.
    assign w_unused_bits = ^{w_sel_addr[31:ADDR_W+2], w_sel_addr[1:0]};

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_ack ? mem_rdata : r_i_rdata;
    assign d_rdata = r_d_ack ? mem_rdata : r_d_rdata;

endmodule
